// File: rtl/datapath_controller.sv
// Multi-cycle control unit for the 16-bit processor/FIR datapath.
// It fetches an instruction, decodes the opcode and then drives the datapath and memory control strobes.
module datapath_controller #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Instruction,
    input  logic        Cout,
    input  logic        Zout,
    input  logic        memDataReady,
    output logic        readMem,
    output logic        writeMem,
    output logic        ResetPC,
    output logic        PCplusI,
    output logic        PCplus1,
    output logic        RplusI,
    output logic        Rplus0,
    output logic        AaddB,
    output logic        AmulB,
    output logic        IRload,
    output logic        Address_on_Databus,
    output logic        ALU_on_Databus,
    output logic        Cset,
    output logic        Creset,
    output logic        Zset,
    output logic        Zreset,
    output logic        Shadow,
    output logic        SRload,
    output logic        halted
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_ADD    = 4'd3;
    localparam logic [3:0] S_MUL    = 4'd4;
    localparam logic [3:0] S_STORE  = 4'd5;
    localparam logic [3:0] S_JUMP   = 4'd6;
    localparam logic [3:0] S_INC    = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HLT  = 4'b0001;
    localparam logic [3:0] OP_SETZ = 4'b0010;
    localparam logic [3:0] OP_CLRZ = 4'b0011;
    localparam logic [3:0] OP_SETC = 4'b0100;
    localparam logic [3:0] OP_CLRC = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_BRC  = 4'b1010;
    localparam logic [3:0] OP_STA  = 4'b1011;

    // The counter is loaded with MUL_CYCLES-1 so that S_MUL lasts exactly MUL_CYCLES cycles.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] mulCnt_q, mulCnt_d;
    logic [3:0] opcode;
    logic       shadowBit;
    logic       unusedInstrBits;

    assign opcode          = Instruction[15:12];
    assign shadowBit       = Instruction[11];
    assign unusedInstrBits = ^Instruction[10:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            mulCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mulCnt_q <= mulCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mulCnt_d = mulCnt_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (memDataReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT: state_d = S_HALT;
                    OP_ADD: state_d = S_ADD;
                    OP_MUL: begin
                        state_d  = S_MUL;
                        mulCnt_d = MUL_LOAD;
                    end
                    OP_JMP: state_d = S_JUMP;
                    OP_BRZ: state_d = Zout ? S_JUMP : S_INC;
                    OP_BRC: state_d = Cout ? S_JUMP : S_INC;
                    OP_STA: state_d = S_STORE;
                    default: state_d = S_INC;
                endcase
            end
            S_ADD: state_d = S_INC;
            S_MUL: begin
                if (mulCnt_q == 4'd0) begin
                    state_d = S_INC;
                end else begin
                    mulCnt_d = mulCnt_q - 4'd1;
                end
            end
            S_STORE: begin
                if (memDataReady) begin
                    state_d = S_INC;
                end
            end
            S_JUMP:  state_d = S_FETCH;
            S_INC:   state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Strobes decode from state and Instruction only; memDataReady gates IRload alone.
    always_comb begin
        readMem            = 1'b0;
        writeMem           = 1'b0;
        ResetPC            = 1'b0;
        PCplusI            = 1'b0;
        PCplus1            = 1'b0;
        RplusI             = 1'b0;
        Rplus0             = 1'b0;
        AaddB              = 1'b0;
        AmulB              = 1'b0;
        IRload             = 1'b0;
        Address_on_Databus = 1'b0;
        ALU_on_Databus     = 1'b0;
        Cset               = 1'b0;
        Creset             = 1'b0;
        Zset               = 1'b0;
        Zreset             = 1'b0;
        Shadow             = 1'b0;
        SRload             = 1'b0;
        halted             = 1'b0;
        case (state_q)
            S_RESET: ResetPC = 1'b1;
            S_FETCH: begin
                Rplus0  = 1'b1;
                readMem = 1'b1;
                IRload  = memDataReady;
            end
            S_DECODE: begin
                case (opcode)
                    OP_SETZ: Zset   = 1'b1;
                    OP_CLRZ: Zreset = 1'b1;
                    OP_SETC: Cset   = 1'b1;
                    OP_CLRC: Creset = 1'b1;
                    default: ;
                endcase
            end
            S_ADD: begin
                AaddB          = 1'b1;
                ALU_on_Databus = 1'b1;
                Shadow         = shadowBit;
                SRload         = ~shadowBit;
            end
            S_MUL: begin
                AmulB = 1'b1;
                if (mulCnt_q == 4'd0) begin
                    ALU_on_Databus = 1'b1;
                    Shadow         = shadowBit;
                    SRload         = ~shadowBit;
                end
            end
            S_STORE: begin
                RplusI             = 1'b1;
                Address_on_Databus = 1'b1;
                writeMem           = 1'b1;
            end
            S_JUMP:  PCplusI = 1'b1;
            S_INC:   PCplus1 = 1'b1;
            S_HALT:  halted  = 1'b1;
            default: ;
        endcase
    end

endmodule
